// File: rtl/drm_input_buffer_reader.sv
// rtl/drm_input_buffer_reader.sv - walks users/CBs of one input-buffer bank and streams each CB as framed beats
// Row reads are credit-gated against a small skid FIFO so back-pressure never loses data.
module drm_input_buffer_reader #(
    parameter int MAX_USERS  = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      i_core_clk,
    input  logic                      i_rx_rstn,
    input  logic                      i_rdm_start,
    input  logic                      i_rd_bank,
    input  logic [3:0]                i_user_num,
    input  logic [MAX_USERS*8-1:0]    i_users_cb_num,
    input  logic [MAX_USERS*8-1:0]    i_users_e0_cb_num,
    input  logic [MAX_USERS*16-1:0]   i_users_e0_sz,
    input  logic [MAX_USERS*16-1:0]   i_users_e1_sz,
    input  logic [MAX_USERS*16-1:0]   i_users_input_buffer_start,
    output logic                      o_rd_en,
    output logic [10:0]               o_rd_addr,
    input  logic [767:0]              i_rd_data,
    output logic                      o_cb_valid,
    input  logic                      i_cb_ready,
    output logic [767:0]              o_cb_data,
    output logic                      o_cb_sop,
    output logic                      o_cb_eop,
    output logic [$clog2(MAX_USERS)-1:0] o_cb_user_idx,
    output logic [7:0]                o_cb_idx,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int UW = $clog2(MAX_USERS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [3:0] MAX_U4 = 4'(MAX_USERS);

    typedef enum logic [1:0] {S_IDLE, S_USER_SETUP, S_READ, S_DRAIN} state_t;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [UW-1:0] user;
        logic [7:0]    cb;
    } tag_t;

    typedef struct packed {
        logic [767:0] data;
        tag_t         tag;
    } entry_t;

    state_t                  state_q, state_d;
    logic                    bank_q, bank_d;
    logic [3:0]              user_num_q, user_num_d;
    logic [MAX_USERS*8-1:0]  cb_num_q, cb_num_d;
    logic [MAX_USERS*8-1:0]  e0_cb_num_q, e0_cb_num_d;
    logic [MAX_USERS*16-1:0] e0_sz_q, e0_sz_d;
    logic [MAX_USERS*16-1:0] e1_sz_q, e1_sz_d;
    logic [MAX_USERS*10-1:0] start_row_q, start_row_d;
    logic [3:0]              user_q, user_d;
    logic [9:0]              row_q, row_d;
    logic [15:0]             rem_q, rem_d;
    logic [7:0]              cb_q, cb_d;
    logic                    inflight_q, inflight_d;
    tag_t                    sb_q, sb_d;
    entry_t                  mem_q [FIFO_DEPTH];
    entry_t                  mem_d [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;

    logic [7:0]    cb_num_a    [MAX_USERS];
    logic [7:0]    e0_cb_num_a [MAX_USERS];
    logic [15:0]   e0_sz_a     [MAX_USERS];
    logic [15:0]   e1_sz_a     [MAX_USERS];
    logic [9:0]    start_row_a [MAX_USERS];
    logic [UW-1:0] uidx;
    logic [15:0]   cur_size;
    logic          last_cb;
    logic          push, pop, can_issue, drained, rd_en;
    logic [CW:0]   credits_used;
    logic          unused_start;

    function automatic logic [15:0] cb_size(input logic [7:0] cb, input logic [7:0] e0n,
                                            input logic [15:0] e0, input logic [15:0] e1);
        return (cb < e0n) ? e0 : e1;
    endfunction

    always_comb begin
        unused_start = 1'b0;
        for (int i = 0; i < MAX_USERS; i++) begin
            cb_num_a[i]    = cb_num_q[i*8 +: 8];
            e0_cb_num_a[i] = e0_cb_num_q[i*8 +: 8];
            e0_sz_a[i]     = e0_sz_q[i*16 +: 16];
            e1_sz_a[i]     = e1_sz_q[i*16 +: 16];
            start_row_a[i] = start_row_q[i*10 +: 10];
            unused_start   = unused_start ^ (^{i_users_input_buffer_start[i*16+14 +: 2],
                                               i_users_input_buffer_start[i*16 +: 4]});
        end
    end

    assign uidx     = user_q[UW-1:0];
    assign cur_size = cb_size(cb_q, e0_cb_num_a[uidx], e0_sz_a[uidx], e1_sz_a[uidx]);
    assign last_cb  = (cb_q == cb_num_a[uidx] - 8'd1);

    // Beats already buffered plus the read still in flight, minus one leaving this cycle.
    assign push         = inflight_q;
    assign pop          = (count_q != '0) && i_cb_ready;
    assign credits_used = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign can_issue    = credits_used < (CW+1)'(FIFO_DEPTH);
    assign drained      = (count_q == '0) && !inflight_q;

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        user_num_d  = user_num_q;
        cb_num_d    = cb_num_q;
        e0_cb_num_d = e0_cb_num_q;
        e0_sz_d     = e0_sz_q;
        e1_sz_d     = e1_sz_q;
        start_row_d = start_row_q;
        user_d      = user_q;
        row_d       = row_q;
        rem_d       = rem_q;
        cb_d        = cb_q;
        sb_d        = sb_q;
        inflight_d  = 1'b0;
        rd_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_rdm_start) begin
                    bank_d      = i_rd_bank;
                    user_num_d  = (i_user_num > MAX_U4) ? MAX_U4 : i_user_num;
                    cb_num_d    = i_users_cb_num;
                    e0_cb_num_d = i_users_e0_cb_num;
                    e0_sz_d     = i_users_e0_sz;
                    e1_sz_d     = i_users_e1_sz;
                    for (int i = 0; i < MAX_USERS; i++) begin
                        start_row_d[i*10 +: 10] = i_users_input_buffer_start[i*16+4 +: 10];
                    end
                    user_d  = '0;
                    state_d = S_USER_SETUP;
                end
            end
            S_USER_SETUP: begin
                if (user_q >= user_num_q) begin
                    state_d = S_DRAIN;
                end else if (cb_num_a[uidx] == 8'd0) begin
                    user_d = user_q + 4'd1;
                end else begin
                    row_d   = start_row_a[uidx];
                    cb_d    = 8'd0;
                    rem_d   = cb_size(8'd0, e0_cb_num_a[uidx], e0_sz_a[uidx], e1_sz_a[uidx]);
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (rem_q == 16'd0) begin
                    // Zero-length CB: no read, just move on to the next CB.
                    if (last_cb) begin
                        user_d  = user_q + 4'd1;
                        state_d = S_USER_SETUP;
                    end else begin
                        cb_d  = cb_q + 8'd1;
                        rem_d = cb_size(cb_q + 8'd1, e0_cb_num_a[uidx], e0_sz_a[uidx], e1_sz_a[uidx]);
                    end
                end else if (can_issue) begin
                    rd_en       = 1'b1;
                    inflight_d  = 1'b1;
                    sb_d.sop    = (rem_q == cur_size);
                    sb_d.eop    = (rem_q == 16'd1);
                    sb_d.user   = uidx;
                    sb_d.cb     = cb_q;
                    row_d       = row_q + 10'd1;
                    rem_d       = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        if (last_cb) begin
                            user_d  = user_q + 4'd1;
                            state_d = S_USER_SETUP;
                        end else begin
                            cb_d  = cb_q + 8'd1;
                            rem_d = cb_size(cb_q + 8'd1, e0_cb_num_a[uidx], e0_sz_a[uidx], e1_sz_a[uidx]);
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (drained) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) begin
            mem_d[wr_ptr_q].data = i_rd_data;
            mem_d[wr_ptr_q].tag  = sb_q;
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state_q     <= S_IDLE;
            bank_q      <= 1'b0;
            user_num_q  <= '0;
            cb_num_q    <= '0;
            e0_cb_num_q <= '0;
            e0_sz_q     <= '0;
            e1_sz_q     <= '0;
            start_row_q <= '0;
            user_q      <= '0;
            row_q       <= '0;
            rem_q       <= '0;
            cb_q        <= '0;
            inflight_q  <= 1'b0;
            sb_q        <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            user_num_q  <= user_num_d;
            cb_num_q    <= cb_num_d;
            e0_cb_num_q <= e0_cb_num_d;
            e0_sz_q     <= e0_sz_d;
            e1_sz_q     <= e1_sz_d;
            start_row_q <= start_row_d;
            user_q      <= user_d;
            row_q       <= row_d;
            rem_q       <= rem_d;
            cb_q        <= cb_d;
            inflight_q  <= inflight_d;
            sb_q        <= sb_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign o_rd_en       = rd_en;
    assign o_rd_addr     = {bank_q, row_q};
    assign o_cb_valid    = (count_q != '0);
    assign o_cb_data     = mem_q[rd_ptr_q].data;
    assign o_cb_sop      = mem_q[rd_ptr_q].tag.sop;
    assign o_cb_eop      = mem_q[rd_ptr_q].tag.eop;
    assign o_cb_user_idx = mem_q[rd_ptr_q].tag.user;
    assign o_cb_idx      = mem_q[rd_ptr_q].tag.cb;
    assign o_done        = (state_q == S_DRAIN) && drained;
    assign o_busy        = (state_q != S_IDLE) && !o_done;

endmodule

// File: tb/tb_drm_input_buffer_reader.sv
// tb/tb_drm_input_buffer_reader.sv - scoreboard bench for drm_input_buffer_reader
module tb_drm_input_buffer_reader;

    typedef struct packed {
        logic [767:0] data;
        logic         sop;
        logic         eop;
        logic [2:0]   user;
        logic [7:0]   cb;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_rdm_start, i_rd_bank, i_cb_ready;
    logic [3:0]   i_user_num;
    logic [63:0]  i_users_cb_num, i_users_e0_cb_num;
    logic [127:0] i_users_e0_sz, i_users_e1_sz, i_users_input_buffer_start;
    logic [767:0] i_rd_data;
    logic         o_rd_en, o_cb_valid, o_cb_sop, o_cb_eop, o_busy, o_done;
    logic [10:0]  o_rd_addr;
    logic [767:0] o_cb_data;
    logic [2:0]   o_cb_user_idx;
    logic [7:0]   o_cb_idx;

    int n_checks = 0, n_pass = 0;
    int cyc = 0;
    int rd_cnt, acc_cnt, done_cnt = 0;
    int t_start, t_first_rd, t_last_rd, t_first_vld, t_last_acc, t_done;
    bit mon_en = 1'b0;
    beat_t      exp_q[$];
    logic [10:0] addr_q[$];
    beat_t      e;
    logic [10:0] ea;
    logic       stalled = 1'b0;
    logic [767:0] held_data;
    logic [12:0]  held_tag;

    drm_input_buffer_reader #(.MAX_USERS(8), .FIFO_DEPTH(2)) dut (
        .i_core_clk(clk), .i_rx_rstn(rst_n), .i_rdm_start(i_rdm_start), .i_rd_bank(i_rd_bank),
        .i_user_num(i_user_num), .i_users_cb_num(i_users_cb_num), .i_users_e0_cb_num(i_users_e0_cb_num),
        .i_users_e0_sz(i_users_e0_sz), .i_users_e1_sz(i_users_e1_sz),
        .i_users_input_buffer_start(i_users_input_buffer_start),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
        .o_cb_valid(o_cb_valid), .i_cb_ready(i_cb_ready), .o_cb_data(o_cb_data),
        .o_cb_sop(o_cb_sop), .o_cb_eop(o_cb_eop), .o_cb_user_idx(o_cb_user_idx),
        .o_cb_idx(o_cb_idx), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [767:0] ram_word(input logic [10:0] a);
        logic [767:0] w;
        for (int k = 0; k < 24; k++) w[k*32 +: 32] = {a, 8'(k), ~a, 2'b01};
        return w;
    endfunction

    always @(posedge clk) i_rd_data <= o_rd_en ? ram_word(o_rd_addr) : '0;

    task automatic check(input string tag, input logic [767:0] got, input logic [767:0] want);
        n_checks++;
        if (got !== want) $display("FAIL %s got=%0h want=%0h", tag, got, want);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (o_rd_en) begin
                rd_cnt++;
                t_last_rd = cyc;
                if (t_first_rd < 0) t_first_rd = cyc;
                if (addr_q.size() == 0) check("extra_read", 1, 0);
                else begin
                    ea = addr_q.pop_front();
                    check("rd_addr", o_rd_addr, ea);
                end
            end
            if (o_cb_valid && t_first_vld < 0) t_first_vld = cyc;
            if (o_cb_valid && !i_cb_ready) begin
                if (stalled) begin
                    check("stall_data", o_cb_data, held_data);
                    check("stall_tag", {o_cb_sop, o_cb_eop, o_cb_user_idx, o_cb_idx}, held_tag);
                end
                stalled   = 1'b1;
                held_data = o_cb_data;
                held_tag  = {o_cb_sop, o_cb_eop, o_cb_user_idx, o_cb_idx};
            end else stalled = 1'b0;
            if (o_cb_valid && i_cb_ready) begin
                acc_cnt++;
                t_last_acc = cyc;
                if (exp_q.size() == 0) check("extra_beat", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("beat_data", o_cb_data, e.data);
                    check("beat_tag", {o_cb_sop, o_cb_eop, o_cb_user_idx, o_cb_idx},
                          {e.sop, e.eop, e.user, e.cb});
                end
            end
            if (o_done) begin
                done_cnt++;
                t_done = cyc;
                check("done_all_seen", exp_q.size() + addr_q.size(), 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_clear();
        i_user_num = 0; i_users_cb_num = '0; i_users_e0_cb_num = '0;
        i_users_e0_sz = '0; i_users_e1_sz = '0; i_users_input_buffer_start = '0;
    endtask

    task automatic cfg_user(input int u, input int cbn, input int e0n, input int e0, input int e1, input int row);
        i_users_cb_num[u*8 +: 8]     = 8'(cbn);
        i_users_e0_cb_num[u*8 +: 8]  = 8'(e0n);
        i_users_e0_sz[u*16 +: 16]    = 16'(e0);
        i_users_e1_sz[u*16 +: 16]    = 16'(e1);
        i_users_input_buffer_start[u*16 +: 16] = 16'(row << 4) | 16'hC003;
    endtask

    // Reference walk of the bank: every row read and every beat in delivery order.
    task automatic build_expected(input logic bank);
        int un;
        un = (i_user_num > 8) ? 8 : int'(i_user_num);
        for (int u = 0; u < un; u++) begin
            int cbn, e0n, e0, e1;
            logic [9:0] row;
            cbn = i_users_cb_num[u*8 +: 8];
            e0n = i_users_e0_cb_num[u*8 +: 8];
            e0  = i_users_e0_sz[u*16 +: 16];
            e1  = i_users_e1_sz[u*16 +: 16];
            row = i_users_input_buffer_start[u*16+4 +: 10];
            for (int c = 0; c < cbn; c++) begin
                int sz;
                sz = (c < e0n) ? e0 : e1;
                for (int r = 0; r < sz; r++) begin
                    logic [10:0] a;
                    beat_t b;
                    a = {bank, row};
                    addr_q.push_back(a);
                    b.data = ram_word(a); b.sop = (r == 0); b.eop = (r == sz - 1);
                    b.user = 3'(u); b.cb = 8'(c);
                    exp_q.push_back(b);
                    row = row + 10'd1;
                end
            end
        end
    endtask

    task automatic start_pass(input logic bank);
        build_expected(bank);
        rd_cnt = 0; acc_cnt = 0;
        t_first_rd = -1; t_last_rd = -1; t_first_vld = -1; t_last_acc = -1; t_done = -1;
        i_rd_bank = bank; i_rdm_start = 1'b1; t_start = cyc;
        tick(1);
        i_rdm_start = 1'b0; i_rd_bank = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        for (int i = 0; i < budget && done_cnt == base; i++) tick(1);
        check("done_seen", 768'(done_cnt > base), 1);
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 200 && acc_cnt < n; i++) tick(1);
        check("acc_reached", 768'(acc_cnt >= n), 1);
    endtask

    int base, rd0, late;

    initial begin
        rst_n = 1'b0; i_rdm_start = 1'b0; i_rd_bank = 1'b0; i_cb_ready = 1'b1;
        cfg_clear();
        tick(3);
        check("rst_data", o_cb_data, 0);
        check("rst_ctl", {o_rd_en, o_rd_addr, o_cb_valid, o_cb_sop, o_cb_eop, o_cb_user_idx,
                          o_cb_idx, o_busy, o_done}, 0);
        rst_n = 1'b1; mon_en = 1'b1;
        tick(2);

        // single user, two CBs of different size
        cfg_user(0, 2, 1, 3, 2, 5); i_user_num = 1;
        base = done_cnt;
        start_pass(1);
        check("busy_hi", o_busy, 1);
        wait_done(base, 100);
        check("busy_lo", o_busy, 0);
        check("t1_first_rd", t_first_rd - t_start, 2);
        check("t1_first_vld", t_first_vld - t_start, 4);
        check("t1_done_lat", t_done - t_last_acc, 1);
        check("t1_rd_burst", t_last_rd - t_first_rd, 4);
        check("t1_beats", acc_cnt, 5);
        tick(3);

        // three users, middle user empty
        cfg_clear();
        cfg_user(0, 2, 2, 2, 0, 10); cfg_user(1, 0, 1, 4, 4, 20); cfg_user(2, 1, 1, 3, 0, 100);
        i_user_num = 3;
        base = done_cnt;
        start_pass(0);
        wait_done(base, 100);
        check("t2_beats", acc_cnt, 7);
        tick(3);

        // user count above 8 clamps to 8
        cfg_clear();
        for (int u = 0; u < 8; u++) cfg_user(u, 1, 1, 1, 0, 200 + u * 3);
        i_user_num = 15;
        base = done_cnt;
        start_pass(1);
        wait_done(base, 200);
        check("t2b_beats", acc_cnt, 8);
        tick(3);

        // back-pressure mid-CB
        cfg_clear();
        cfg_user(0, 1, 1, 8, 0, 300); i_user_num = 1;
        base = done_cnt;
        start_pass(0);
        wait_acc(3);
        i_cb_ready = 1'b0;
        rd0 = rd_cnt; late = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (i >= 4 && o_rd_en) late++;
        end
        check("bp_reads_bounded", 768'((rd_cnt - rd0) <= 2), 1);
        check("bp_no_late_reads", late, 0);
        check("bp_valid_held", o_cb_valid, 1);
        i_cb_ready = 1'b1;
        wait_done(base, 100);
        check("bp_beats", acc_cnt, 8);
        tick(3);

        // row counter wrap
        cfg_clear();
        cfg_user(0, 1, 1, 4, 0, 1022); i_user_num = 1;
        base = done_cnt;
        start_pass(1);
        wait_done(base, 100);
        check("wrap_reads", rd_cnt, 4);
        tick(3);

        // no users
        cfg_clear();
        base = done_cnt;
        start_pass(0);
        wait_done(base, 20);
        check("u0_done_lat", t_done - t_start, 2);
        check("u0_reads", rd_cnt, 0);
        tick(3);

        // zero-length leading CB
        cfg_clear();
        cfg_user(0, 3, 1, 0, 2, 50); i_user_num = 1;
        base = done_cnt;
        start_pass(0);
        wait_done(base, 100);
        check("zsz_beats", acc_cnt, 4);
        tick(3);

        // start while busy is ignored
        cfg_clear();
        cfg_user(0, 2, 2, 5, 0, 60); i_user_num = 1;
        base = done_cnt;
        start_pass(0);
        tick(2);
        i_rdm_start = 1'b1; i_rd_bank = 1'b1; i_user_num = 2;
        tick(1);
        i_rdm_start = 1'b0; i_rd_bank = 1'b0;
        wait_done(base, 100);
        tick(10);
        check("busy_start_done", done_cnt - base, 1);
        check("busy_start_reads", rd_cnt, 10);

        // reset in the middle of a pass
        cfg_clear();
        cfg_user(0, 1, 1, 8, 0, 400); i_user_num = 1;
        base = done_cnt;
        start_pass(1);
        wait_acc(3);
        rst_n = 1'b0;
        @(negedge clk);
        mon_en = 1'b0;
        check("mid_rst_data", o_cb_data, 0);
        check("mid_rst_ctl", {o_rd_en, o_rd_addr, o_cb_valid, o_cb_sop, o_cb_eop, o_cb_user_idx,
                              o_cb_idx, o_busy, o_done}, 0);
        exp_q.delete(); addr_q.delete();
        tick(2);
        mon_en = 1'b1; rd0 = rd_cnt;
        rst_n = 1'b1;
        tick(6);
        check("mid_rst_no_done", done_cnt - base, 0);
        check("mid_rst_no_reads", rd_cnt - rd0, 0);
        start_pass(1);
        wait_done(base, 100);
        check("post_rst_beats", acc_cnt, 8);
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
